// File: rtl/patch_gradient_if.sv
// Pixel-in / gradient-out stream bundle for patch_gradient.
// The master side is the pixel source and the gradient consumer. The slave side is the gradient stage.
interface patch_gradient_if #(
  parameter int PR         = 16,
  parameter int PC         = 16,
  parameter int DATA_WIDTH = 8
);
  localparam int H  = 2*PR+1;
  localparam int W  = 2*PC+1;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam int GW = DATA_WIDTH+1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [GW-1:0]         out_ix;
  logic [GW-1:0]         out_iy;
  logic [DATA_WIDTH-1:0] out_pix;
  logic [RW-1:0]         out_row;
  logic [CW-1:0]         out_col;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_ix, out_iy, out_pix, out_row, out_col, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_ix, out_iy, out_pix, out_row, out_col, out_last
  );
endinterface

// File: rtl/patch_gradient.sv
// Streaming central-difference gradient over a raster patch.
// Two line buffers and a 3x3 window produce one word per interior pixel.
module patch_gradient #(
  parameter int PR         = 16,
  parameter int PC         = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  patch_gradient_if.slave s
);
  localparam int H  = 2*PR+1;
  localparam int W  = 2*PC+1;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam int GW = DATA_WIDTH+1;
  localparam logic [RW-1:0] ROW_LAST = RW'(H-1);
  localparam logic [CW-1:0] COL_LAST = CW'(W-1);

  logic [RW-1:0]         in_row;
  logic [CW-1:0]         in_col;
  logic [DATA_WIDTH-1:0] lb0 [W];
  logic [DATA_WIDTH-1:0] lb1 [W];
  logic [DATA_WIDTH-1:0] top_rd, mid_rd;
  // The current window column is the live LB read and input. Only the two older columns are registered.
  logic [DATA_WIDTH-1:0] top_d1, mid_d1, mid_d2, bot_d1;
  logic                  acc, emit;

  function automatic logic [GW-1:0] diff(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  assign s.in_ready = !s.out_valid || s.out_ready;
  assign acc        = s.in_valid && s.in_ready;
  assign emit       = acc && (in_row >= RW'(2)) && (in_col >= CW'(2));
  assign top_rd     = lb0[in_col];
  assign mid_rd     = lb1[in_col];

  // Storage is not reset. The counters alone decide which contents are used.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[in_col] <= mid_rd;
      lb1[in_col] <= s.in_data;
      top_d1      <= top_rd;
      mid_d1      <= mid_rd;
      mid_d2      <= mid_d1;
      bot_d1      <= s.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_row      <= '0;
      in_col      <= '0;
      s.out_valid <= 1'b0;
      s.out_last  <= 1'b0;
      s.out_ix    <= '0;
      s.out_iy    <= '0;
      s.out_pix   <= '0;
      s.out_row   <= '0;
      s.out_col   <= '0;
    end else begin
      if (acc) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
      end
      if (emit) begin
        s.out_valid <= 1'b1;
        s.out_last  <= (in_row == ROW_LAST) && (in_col == COL_LAST);
        s.out_ix    <= diff(mid_rd, mid_d2);
        s.out_iy    <= diff(bot_d1, top_d1);
        s.out_pix   <= mid_d1;
        s.out_row   <= in_row - RW'(1);
        s.out_col   <= in_col - CW'(1);
      end else if (s.out_ready) begin
        s.out_valid <= 1'b0;
        s.out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/patch_gradient.md
# patch_gradient

Streaming spatial-gradient stage for the pyramidal LK datapath. It sits downstream of the patch address generator and its pixel FIFO, and consumes the raster-ordered (2·PR+1)×(2·PC+1) patch one pixel per handshake. It uses two line buffers and a 3×3 window to emit central-difference gradients Ix and Iy with the centre pixel for every interior patch position. The LK accumulation stage is its consumer.

## Interface
Parameters:
- PR, 16, patch half-height; patch height H = 2·PR+1
- PC, 16, patch half-width; patch width W = 2·PC+1
- DATA_WIDTH, 8, unsigned pixel width
- Derived: RW = $clog2(H), CW = $clog2(W), GW = DATA_WIDTH+1

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input pixel valid (from FIFO, non-empty side)
- in_data  in  DATA_WIDTH  pixel, raster order: row 0 col 0 first
- in_ready  out  1  block accepts pixel this cycle; drives FIFO r_en
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts output word
- out_ix  out  GW  signed I[r][c+1] − I[r][c−1]
- out_iy  out  GW  signed I[r+1][c] − I[r−1][c]
- out_pix  out  DATA_WIDTH  centre pixel I[r][c]
- out_row  out  RW  centre row r, 1..H−2
- out_col  out  CW  centre col c, 1..W−2
- out_last  out  1  high with the final interior word (r=H−2, c=W−2)

## Operation
- Input accept: acc = in_valid && in_ready. in_ready = !out_valid || out_ready (combinational from out_ready).
- Counters: in_col 0..W−1 and in_row 0..H−1 advance on acc only. in_col wraps to 0 at W−1 and increments in_row. At (H−1, W−1) both wrap to 0, so the next patch starts with no idle cycle.
- Line buffers: LB1 holds the previous row and LB0 holds the row before that. Each buffer has W entries indexed by in_col. On acc, read both at in_col before writing: LB0[in_col] ← LB1[in_col] and LB1[in_col] ← in_data. Read-before-write is mandatory.
- Window: three 3-tap column shift registers (top = LB0 read, mid = LB1 read, bottom = in_data) shift on acc. Shift contents carry across row boundaries; they are only used when in_col ≥ 2.
- Emit condition: acc with in_row ≥ 2 and in_col ≥ 2 produces a word for centre (in_row−1, in_col−1):
  - ix = mid[in_col] − mid[in_col−2]
  - iy = bottom[in_col−1] − top[in_col−1]
  - pix = mid[in_col−1]
  - Arithmetic: operands are zero-extended to GW, then subtracted in two's complement. The range is ±(2^DATA_WIDTH − 1), so nothing saturates.
- Accepted pixels in row 0, row 1, col 0 or col 1 produce no output.
- Per patch: exactly (H−2)·(W−2) words, in raster order of centre coordinates.
- Line-buffer and shift-register contents are not reset. Correctness relies only on the counters, because no output uses data older than the current patch.

## Timing
- Reset values: out_valid=0, out_last=0, out_ix=0, out_iy=0, out_pix=0, out_row=0, out_col=0. Counters are 0. in_ready=1 in the first cycle after reset.
- Latency: output registers load on the edge of the emitting acc, so out_valid rises 1 cycle after that acc.
- Throughput: 1 pixel per cycle when out_ready stays high.
- Backpressure: while out_valid && !out_ready, all output fields hold stable, in_ready=0, and the counters and buffers freeze.
- Output handshake: out_valid clears on the edge where out_ready=1, unless a new word loads in the same cycle (simultaneous accept and emit gives a back-to-back word).
- out_last is qualified by out_valid and lasts exactly one transfer per patch.
- Patch boundary: the first word of the next patch appears at the earliest after that patch's pixel (2,2). No word ever mixes two patches.
- Reset mid-patch: counters and out_valid clear on the next edge, and the next accepted pixel is treated as (0,0).
- Latency from the first pixel to the first word: 2·W+3 accepts plus 1 cycle.

## Test plan
- Ramp I[r][c]=2r+c, defaults, out_ready=1 → 961 words. Every word has ix=2 and iy=4. pix matches 2r+c. Coordinates run (1,1)…(31,31). out_last is on (31,31) only.
- Constant 8'hA5 patch → all ix=0 and iy=0, and pix=8'hA5 for all 961 words.
- Descending I=255−c with I=255−r on alternate patches → ix=9'h1FE (−2) and iy=0. Then ix=0 and iy=9'h1FE (−2).
- Random image, in_valid random 70% and out_ready random 50% → word stream matches the reference model exactly. in_ready=0 whenever out_valid && !out_ready. Held outputs stay stable while stalled.
- Reset asserted after 500 accepted pixels, then a full ramp patch → exactly 961 correct words and no stale output after reset.
- Two patches back-to-back with in_valid held high → 1922 words. The second patch's first word is (1,1) and appears only after its 69th accepted pixel (pixel (2,2)). out_last pulses twice.
